// File: rtl/issueq_release_if.sv
`default_nettype none
// ============================================================================
// Module      : issueq_release_if
// Description : Grant/release bus between the select/grant logic, the
//               release collector and the issue-queue free list. Carries the
//               up-to-four entries issued per cycle and the up-to-four
//               entries returned to the free list per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
interface issueq_release_if #(
    parameter int SIZE_ISSUEQ_LOG = 5
) ();

    // Entries issued by select/grant this cycle
    logic [SIZE_ISSUEQ_LOG-1:0] grantedEntry0_i;
    logic [SIZE_ISSUEQ_LOG-1:0] grantedEntry1_i;
    logic [SIZE_ISSUEQ_LOG-1:0] grantedEntry2_i;
    logic [SIZE_ISSUEQ_LOG-1:0] grantedEntry3_i;
    logic                       grantedValid0_i;
    logic                       grantedValid1_i;
    logic                       grantedValid2_i;
    logic                       grantedValid3_i;

    // Entries returned to the free list this cycle
    logic [SIZE_ISSUEQ_LOG-1:0] freedEntry0_o;
    logic [SIZE_ISSUEQ_LOG-1:0] freedEntry1_o;
    logic [SIZE_ISSUEQ_LOG-1:0] freedEntry2_o;
    logic [SIZE_ISSUEQ_LOG-1:0] freedEntry3_o;
    logic                       freedValid0_o;
    logic                       freedValid1_o;
    logic                       freedValid2_o;
    logic                       freedValid3_o;

    // Driver of grants / consumer of freed entries
    modport master (
        output grantedEntry0_i, grantedEntry1_i, grantedEntry2_i, grantedEntry3_i,
        output grantedValid0_i, grantedValid1_i, grantedValid2_i, grantedValid3_i,
        input  freedEntry0_o, freedEntry1_o, freedEntry2_o, freedEntry3_o,
        input  freedValid0_o, freedValid1_o, freedValid2_o, freedValid3_o
    );

    // Release collector side
    modport slave (
        input  grantedEntry0_i, grantedEntry1_i, grantedEntry2_i, grantedEntry3_i,
        input  grantedValid0_i, grantedValid1_i, grantedValid2_i, grantedValid3_i,
        output freedEntry0_o, freedEntry1_o, freedEntry2_o, freedEntry3_o,
        output freedValid0_o, freedValid1_o, freedValid2_o, freedValid3_o
    );

endinterface
`default_nettype wire

// File: rtl/issueq_release.sv
`default_nettype none
// ============================================================================
// Module      : issueq_release
// Description : Issue-queue free-list return path. Entries released by
//               select/grant and by mispredict squash are collected into a
//               pending bit vector; up to four pending entries are returned
//               to the free list per cycle, lowest index first. A sticky
//               flag records any attempt to release an entry that is
//               already waiting to be returned.
// Revision    : 1.0 - initial release
// ============================================================================
module issueq_release #(
    parameter int SIZE_ISSUEQ     = 32,
    parameter int SIZE_ISSUEQ_LOG = 5
) (
    input  wire logic                     clock,
    input  wire logic                     reset_n,

    input  wire logic                     ctrlVerified_i,
    input  wire logic                     ctrlMispredict_i,
    input  wire logic [SIZE_ISSUEQ-1:0]   mispredictVector_i,

    issueq_release_if.slave               relBus,

    output logic [SIZE_ISSUEQ_LOG:0]      pendingCnt_o,
    output logic                          doubleFree_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Number of grant ports and of free-list return slots per cycle
    localparam int c_PORTS = 4;

    // Entry count widened to index width + 1 so out-of-range grant indices
    // can be compared against it (matters only for non-power-of-2 sizes).
    localparam logic [SIZE_ISSUEQ_LOG:0] c_SIZE_EXT = (SIZE_ISSUEQ_LOG + 1)'(SIZE_ISSUEQ);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [SIZE_ISSUEQ-1:0]             r_pendingVec;
    logic                               r_doubleFree;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [c_PORTS-1:0][SIZE_ISSUEQ_LOG-1:0] w_grantEntry;
    logic [c_PORTS-1:0]                      w_grantValid;

    logic [c_PORTS-1:0][SIZE_ISSUEQ_LOG-1:0] w_freedEntry;
    logic [c_PORTS-1:0]                      w_freedValid;
    logic [2:0]                              w_found;

    logic [SIZE_ISSUEQ-1:0]             w_selMask;
    logic [SIZE_ISSUEQ-1:0]             w_grantMask;
    logic [SIZE_ISSUEQ-1:0]             w_squashMask;
    logic [SIZE_ISSUEQ-1:0]             w_releaseMask;
    logic [SIZE_ISSUEQ-1:0]             w_keptVec;
    logic [SIZE_ISSUEQ-1:0]             w_nextVec;
    logic                               w_dupHit;
    logic [SIZE_ISSUEQ_LOG:0]           w_pendingCnt;

    // ------------------------------------------------------------------------
    // Gather the individual grant ports into indexable vectors
    // ------------------------------------------------------------------------
    assign w_grantEntry[0] = relBus.grantedEntry0_i;
    assign w_grantEntry[1] = relBus.grantedEntry1_i;
    assign w_grantEntry[2] = relBus.grantedEntry2_i;
    assign w_grantEntry[3] = relBus.grantedEntry3_i;

    assign w_grantValid[0] = relBus.grantedValid0_i;
    assign w_grantValid[1] = relBus.grantedValid1_i;
    assign w_grantValid[2] = relBus.grantedValid2_i;
    assign w_grantValid[3] = relBus.grantedValid3_i;

    // ------------------------------------------------------------------------
    // Pick the four lowest pending entries. Slots fill in order, so the
    // valids are always packed from slot 0 upwards and unused slots stay 0.
    // Only registered state feeds this, so there is no input-to-output path.
    // ------------------------------------------------------------------------
    always_comb begin
        w_selMask    = '0;
        w_freedValid = '0;
        w_freedEntry = '0;
        w_found      = 3'd0;
        for (int i = 0; i < SIZE_ISSUEQ; i++) begin
            if (r_pendingVec[i] && (w_found < 3'd4)) begin
                w_freedEntry[w_found[1:0]] = SIZE_ISSUEQ_LOG'(i);
                w_freedValid[w_found[1:0]] = 1'b1;
                w_selMask[i]               = 1'b1;
                w_found                    = w_found + 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Population count of the pending vector
    // ------------------------------------------------------------------------
    always_comb begin
        w_pendingCnt = '0;
        for (int i = 0; i < SIZE_ISSUEQ; i++) begin
            w_pendingCnt = w_pendingCnt + (SIZE_ISSUEQ_LOG + 1)'(r_pendingVec[i]);
        end
    end

    // ------------------------------------------------------------------------
    // Decode the grant ports into a mask; duplicates across ports merge, and
    // indices beyond the queue size are dropped.
    // ------------------------------------------------------------------------
    always_comb begin
        w_grantMask = '0;
        for (int n = 0; n < c_PORTS; n++) begin
            if (w_grantValid[n] && ({1'b0, w_grantEntry[n]} < c_SIZE_EXT)) begin
                w_grantMask[w_grantEntry[n]] = 1'b1;
            end
        end
    end

    // A mispredict only counts when the branch actually resolved this cycle
    assign w_squashMask  = (ctrlVerified_i && ctrlMispredict_i) ? mispredictVector_i : '0;
    assign w_releaseMask = w_grantMask | w_squashMask;

    // Entries that remain pending after this cycle's returns. A new release
    // hitting one of these is a double free; hitting an entry being returned
    // this cycle is legal and simply re-queues it (set wins over clear).
    assign w_keptVec = r_pendingVec & ~w_selMask;
    assign w_dupHit  = |(w_releaseMask & w_keptVec);
    assign w_nextVec = w_keptVec | w_releaseMask;

    // ------------------------------------------------------------------------
    // Pending vector and sticky double-free flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pendingVec <= '0;
            r_doubleFree <= 1'b0;
        end else begin
            r_pendingVec <= w_nextVec;
            if (w_dupHit) begin
                r_doubleFree <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign relBus.freedEntry0_o = w_freedEntry[0];
    assign relBus.freedEntry1_o = w_freedEntry[1];
    assign relBus.freedEntry2_o = w_freedEntry[2];
    assign relBus.freedEntry3_o = w_freedEntry[3];

    assign relBus.freedValid0_o = w_freedValid[0];
    assign relBus.freedValid1_o = w_freedValid[1];
    assign relBus.freedValid2_o = w_freedValid[2];
    assign relBus.freedValid3_o = w_freedValid[3];

    assign pendingCnt_o = w_pendingCnt;
    assign doubleFree_o = r_doubleFree;

endmodule
`default_nettype wire

// File: tb/tb_issueq_release.sv
`default_nettype none
// ============================================================================
// Module      : tb_issueq_release
// Description : Directed vector table plus hand-written reset sequences and
//               a randomized scoreboard run for issueq_release.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_issueq_release;

    localparam int SZ = 32;
    localparam int LG = 5;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          ctrlVerified;
    logic          ctrlMispredict;
    logic [SZ-1:0] mispredictVector;
    logic [LG:0]   pendingCnt;
    logic          doubleFree;

    always #5 clock = ~clock;

    issueq_release_if #(.SIZE_ISSUEQ_LOG(LG)) relBus ();

    issueq_release #(
        .SIZE_ISSUEQ     (SZ),
        .SIZE_ISSUEQ_LOG (LG)
    ) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .ctrlVerified_i     (ctrlVerified),
        .ctrlMispredict_i   (ctrlMispredict),
        .mispredictVector_i (mispredictVector),
        .relBus             (relBus),
        .pendingCnt_o       (pendingCnt),
        .doubleFree_o       (doubleFree)
    );

    typedef struct {
        logic             ver;
        logic             mis;
        logic [31:0]      vec;
        logic [3:0]       gv;
        logic [3:0][4:0]  ge;
        logic [3:0]       ev;
        logic [3:0][4:0]  ee;
        logic [5:0]       ecnt;
        logic             edf;
    } vec_t;

    vec_t tbl[$];
    int   tests = 0;
    int   fails = 0;

    function automatic vec_t mk(input logic ver, input logic mis, input logic [31:0] vec,
                                input logic [3:0] gv,
                                input logic [4:0] g0, input logic [4:0] g1,
                                input logic [4:0] g2, input logic [4:0] g3,
                                input logic [3:0] ev,
                                input logic [4:0] e0, input logic [4:0] e1,
                                input logic [4:0] e2, input logic [4:0] e3,
                                input int cnt, input logic df);
        vec_t r;
        r.ver  = ver;
        r.mis  = mis;
        r.vec  = vec;
        r.gv   = gv;
        r.ge   = {g3, g2, g1, g0};
        r.ev   = ev;
        r.ee   = {e3, e2, e1, e0};
        r.ecnt = 6'(cnt);
        r.edf  = df;
        return r;
    endfunction

    task automatic drive(input logic ver, input logic mis, input logic [31:0] vec,
                         input logic [3:0] gv, input logic [3:0][4:0] ge);
        ctrlVerified            = ver;
        ctrlMispredict          = mis;
        mispredictVector        = vec;
        relBus.grantedValid0_i  = gv[0];
        relBus.grantedValid1_i  = gv[1];
        relBus.grantedValid2_i  = gv[2];
        relBus.grantedValid3_i  = gv[3];
        relBus.grantedEntry0_i  = ge[0];
        relBus.grantedEntry1_i  = ge[1];
        relBus.grantedEntry2_i  = ge[2];
        relBus.grantedEntry3_i  = ge[3];
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 4'b0, '0);
    endtask

    task automatic checkBus(input string name, input logic [3:0] ev, input logic [3:0][4:0] ee,
                            input logic [5:0] ecnt, input logic edf);
        logic [3:0]      av;
        logic [3:0][4:0] ae;
        av = {relBus.freedValid3_o, relBus.freedValid2_o, relBus.freedValid1_o, relBus.freedValid0_o};
        ae = {relBus.freedEntry3_o, relBus.freedEntry2_o, relBus.freedEntry1_o, relBus.freedEntry0_o};
        tests++;
        if (av !== ev || ae !== ee) begin
            fails++;
            $display("FAIL %s freed: valid=%b entries=%h, required valid=%b entries=%h",
                     name, av, ae, ev, ee);
        end
        tests++;
        if (pendingCnt !== ecnt || doubleFree !== edf) begin
            fails++;
            $display("FAIL %s status: cnt=%0d doubleFree=%b, required cnt=%0d doubleFree=%b",
                     name, pendingCnt, doubleFree, ecnt, edf);
        end
    endtask

    // Expected free-list returns for a given pending vector
    task automatic lowest4(input logic [31:0] v, output logic [3:0] ev,
                           output logic [3:0][4:0] ee, output logic [31:0] sel);
        int k;
        ev  = '0;
        ee  = '0;
        sel = '0;
        k   = 0;
        for (int i = 0; i < SZ; i++) begin
            if (v[i] && k < 4) begin
                ev[k]  = 1'b1;
                ee[k]  = 5'(i);
                sel[i] = 1'b1;
                k++;
            end
        end
    endtask

    logic [31:0]     mdl;
    logic            mdlDf;
    logic [3:0]      rEv;
    logic [3:0][4:0] rEe;
    logic [31:0]     rSel;
    logic [31:0]     rGm;
    logic [31:0]     rRel;
    logic            rVer;
    logic            rMis;
    logic [31:0]     rVec;
    logic [3:0]      rGv;
    logic [3:0][4:0] rGe;

    initial begin
        // ---------------- directed table ----------------
        // grant {3,7}
        tbl.push_back(mk(0,0,32'h0,       4'b0011, 3,7,0,0,  4'b0011, 3,7,0,0,  2, 0));
        tbl.push_back(mk(0,0,32'h0,       4'b0000, 0,0,0,0,  4'b0000, 0,0,0,0,  0, 0));
        // mispredict 0x1F0: 4..7 then 8
        tbl.push_back(mk(1,1,32'h1F0,     4'b0000, 0,0,0,0,  4'b1111, 4,5,6,7,  5, 0));
        tbl.push_back(mk(0,0,32'h0,       4'b0000, 0,0,0,0,  4'b0001, 8,0,0,0,  1, 0));
        tbl.push_back(mk(0,0,32'h0,       4'b0000, 0,0,0,0,  4'b0000, 0,0,0,0,  0, 0));
        // mispredict without verify, verify without mispredict: ignored
        tbl.push_back(mk(0,1,32'h10,      4'b0000, 0,0,0,0,  4'b0000, 0,0,0,0,  0, 0));
        tbl.push_back(mk(1,0,32'h10,      4'b0000, 0,0,0,0,  4'b0000, 0,0,0,0,  0, 0));
        tbl.push_back(mk(1,1,32'h10,      4'b0000, 0,0,0,0,  4'b0001, 4,0,0,0,  1, 0));
        tbl.push_back(mk(0,0,32'h0,       4'b0000, 0,0,0,0,  4'b0000, 0,0,0,0,  0, 0));
        // squash everything: drains four per cycle over eight cycles
        tbl.push_back(mk(1,1,32'hFFFF_FFFF, 4'b0000, 0,0,0,0, 4'b1111, 0,1,2,3, 32, 0));
        for (int k = 1; k <= 8; k++) begin
            if (k < 8)
                tbl.push_back(mk(0,0,32'h0, 4'b0000, 0,0,0,0, 4'b1111,
                                 5'(4*k), 5'(4*k+1), 5'(4*k+2), 5'(4*k+3), 32-4*k, 0));
            else
                tbl.push_back(mk(0,0,32'h0, 4'b0000, 0,0,0,0, 4'b0000, 0,0,0,0, 0, 0));
        end
        // highest entries, out-of-order grant ports
        tbl.push_back(mk(0,0,32'h0,       4'b0111, 31,0,30,0, 4'b0111, 0,30,31,0, 3, 0));
        tbl.push_back(mk(0,0,32'h0,       4'b0000, 0,0,0,0,  4'b0000, 0,0,0,0,  0, 0));
        // same entry on two ports, and in grant and squash together
        tbl.push_back(mk(0,0,32'h0,       4'b0011, 9,9,0,0,  4'b0001, 9,0,0,0,  1, 0));
        tbl.push_back(mk(0,0,32'h0,       4'b0000, 0,0,0,0,  4'b0000, 0,0,0,0,  0, 0));
        tbl.push_back(mk(1,1,32'h200,     4'b0001, 9,0,0,0,  4'b0001, 9,0,0,0,  1, 0));
        // re-grant of an entry being returned this cycle: re-queued, not an error
        tbl.push_back(mk(0,0,32'h0,       4'b0001, 9,0,0,0,  4'b0001, 9,0,0,0,  1, 0));
        tbl.push_back(mk(0,0,32'h0,       4'b0000, 0,0,0,0,  4'b0000, 0,0,0,0,  0, 0));
        // 9 held back behind 0..3, then re-granted: double free, sticky
        tbl.push_back(mk(1,1,32'h200,     4'b1111, 0,1,2,3,  4'b1111, 0,1,2,3,  5, 0));
        tbl.push_back(mk(0,0,32'h0,       4'b0001, 9,0,0,0,  4'b0001, 9,0,0,0,  1, 1));
        tbl.push_back(mk(0,0,32'h0,       4'b0000, 0,0,0,0,  4'b0000, 0,0,0,0,  0, 1));
        tbl.push_back(mk(0,0,32'h0,       4'b0000, 0,0,0,0,  4'b0000, 0,0,0,0,  0, 1));

        // ---------------- reset with grants active ----------------
        reset_n = 1'b0;
        drive(1'b1, 1'b1, 32'hFFFF_FFFF, 4'b0011, {5'd0, 5'd0, 5'd2, 5'd1});
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkBus("rst_during", 4'b0, '0, 6'd0, 1'b0);
        idle();
        reset_n = 1'b1;
        #1;
        checkBus("rst_release", 4'b0, '0, 6'd0, 1'b0);
        @(posedge clock);
        #1;
        checkBus("rst_after", 4'b0, '0, 6'd0, 1'b0);

        // ---------------- table ----------------
        foreach (tbl[i]) begin
            @(negedge clock);
            drive(tbl[i].ver, tbl[i].mis, tbl[i].vec, tbl[i].gv, tbl[i].ge);
            @(posedge clock);
            #1;
            checkBus($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ee, tbl[i].ecnt, tbl[i].edf);
        end

        // ---------------- reset mid-operation ----------------
        @(negedge clock);
        drive(1'b1, 1'b1, 32'hFFFF_FFFF, 4'b0, '0);
        @(posedge clock);
        #1;
        checkBus("mid_full", 4'b1111, {5'd3, 5'd2, 5'd1, 5'd0}, 6'd32, 1'b1);
        @(negedge clock);
        idle();
        reset_n = 1'b0;
        #1;
        checkBus("mid_reset", 4'b0, '0, 6'd0, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        checkBus("mid_after", 4'b0, '0, 6'd0, 1'b0);

        // ---------------- random scoreboard ----------------
        mdl   = '0;
        mdlDf = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clock);
            lowest4(mdl, rEv, rEe, rSel);
            checkBus($sformatf("rand%0d", c), rEv, rEe, 6'($countones(mdl)), mdlDf);
            rGv  = 4'($urandom & $urandom);
            for (int n = 0; n < 4; n++) rGe[n] = 5'($urandom_range(0, 31));
            rVer = ($urandom_range(0, 7) == 0);
            rMis = 1'($urandom_range(0, 1));
            rVec = $urandom & $urandom & $urandom;
            drive(rVer, rMis, rVec, rGv, rGe);
            rGm = '0;
            for (int n = 0; n < 4; n++) if (rGv[n]) rGm[rGe[n]] = 1'b1;
            rRel = rGm | ((rVer && rMis) ? rVec : 32'h0);
            if (|(rRel & mdl & ~rSel)) mdlDf = 1'b1;
            mdl = (mdl & ~rSel) | rRel;
        end

        // ---------------- bounded drain ----------------
        @(negedge clock);
        idle();
        for (int w = 0; w < 20; w++) begin
            @(negedge clock);
            if (pendingCnt == 0) break;
        end
        tests++;
        if (pendingCnt !== 6'd0) begin
            fails++;
            $display("FAIL drain: cnt=%0d, required 0", pendingCnt);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
